// File: rtl/proc_core_if.sv
// proc_core_if: instruction/observation bus for proc_core.
// The instruction word goes into the core. Operand A, operand B and the
// write-back value come out of it.
// 'master' is the side that presents instructions and observes results
// (fetch logic or a testbench). 'slave' is the core itself.
interface proc_core_if #(
    parameter int XLEN = 32
);
    logic [31:0]     ir;
    logic [XLEN-1:0] a_out;
    logic [XLEN-1:0] b_out;
    logic [XLEN-1:0] w_out;

    modport master (output ir, input a_out, input b_out, input w_out);
    modport slave  (input ir, output a_out, output b_out, output w_out);
endinterface

// File: rtl/proc_core.sv
// proc_core: minimal RV32I-style integer execute core.
// Each cycle it does the following:
//   - decodes the instruction on bus.ir;
//   - reads two registers from a 32-entry register file;
//   - computes an ALU result combinationally;
//   - commits that result to rd on the next rising edge.
// Supported opcodes are OP-IMM, OP and LUI. Any other opcode writes nothing
// and drives w_out to 0.
// Reset is asynchronous and active low. While reset is low the register file
// is cleared and all observation outputs read 0.
// Optional build macro ZERO_REG_EN makes register 0 a hardwired zero. Reads of
// register 0 return 0 and writes to it are dropped. w_out still shows the
// computed value.
module proc_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic               clk,
    input  logic               reset,
    proc_core_if.slave         bus
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int SHW = $clog2(XLEN);

    // Architectural register file
    logic [XLEN-1:0] r_regs [NREGS];

    // Decoded instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_alt;
    logic            w_is_opimm;
    logic            w_is_op;
    logic            w_is_lui;
    logic            w_supported;
    logic            w_we;

    // Operands and results
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_shamt;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_result;

    // Field extraction.
    // ir[30] is the SUB/SRA selector for OP. It is the SRAI selector for
    // OP-IMM shifts.
    assign w_opcode = bus.ir[6:0];
    assign w_funct3 = bus.ir[14:12];
    assign w_rd     = bus.ir[11:7];
    assign w_rs1    = bus.ir[19:15];
    assign w_rs2    = bus.ir[24:20];
    assign w_alt    = bus.ir[30];

    assign w_is_opimm  = (w_opcode == OPC_OP_IMM);
    assign w_is_op     = (w_opcode == OPC_OP);
    assign w_is_lui    = (w_opcode == OPC_LUI);
    assign w_supported = w_is_opimm | w_is_op | w_is_lui;

    // I-type immediate is sign-extended ir[31:20].
    // U-type immediate is ir[31:12] placed above twelve zero bits.
    assign w_imm_i = XLEN'($signed(bus.ir[31:20]));
    assign w_imm_u = XLEN'($signed({bus.ir[31:12], 12'b0}));

    // Register reads are asynchronous.
    // A write committing at the coming edge is not forwarded, so the reads
    // see the pre-edge contents.
`ifdef ZERO_REG_EN
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`else
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];
`endif

    // Operand B is the immediate for OP-IMM/LUI and rs2 for everything else.
    // "Everything else" includes unsupported opcodes, so b_out still shows
    // the rs2 read for them.
    assign w_a = w_rs1_val;
    assign w_b = w_is_lui   ? w_imm_u :
                 w_is_opimm ? w_imm_i : w_rs2_val;

    // One shift amount works for both forms.
    // For OP it is b[4:0]. For OP-IMM it is ir[24:20], which is the low
    // bits of the I-immediate.
    assign w_shamt = w_b[SHW-1:0];
    assign w_lt_s  = ($signed(w_a) < $signed(w_b));
    assign w_lt_u  = (w_a < w_b);

    // ALU: funct3 selects the operation.
    // ir[30] selects SUB only for OP; for OP-IMM that bit belongs to the
    // immediate.
    always_comb begin
        w_alu = '0;
        case (w_funct3)
            F3_ADD:  w_alu = (w_is_op && w_alt) ? (w_a - w_b) : (w_a + w_b);
            F3_SLL:  w_alu = w_a << w_shamt;
            F3_SLT:  w_alu = XLEN'(w_lt_s);
            F3_SLTU: w_alu = XLEN'(w_lt_u);
            F3_XOR:  w_alu = w_a ^ w_b;
            F3_SR:   w_alu = w_alt ? $unsigned($signed(w_a) >>> w_shamt)
                                   : (w_a >> w_shamt);
            F3_OR:   w_alu = w_a | w_b;
            F3_AND:  w_alu = w_a & w_b;
            default: w_alu = '0;
        endcase
    end

    // Result select: LUI passes operand B through; unsupported opcodes give 0.
    always_comb begin
        w_result = '0;
        if (w_is_lui) begin
            w_result = w_b;
        end else if (w_is_opimm || w_is_op) begin
            w_result = w_alu;
        end
    end

    // Write enable. Reset low blocks the write; the async clear takes
    // priority in the register process anyway.
`ifdef ZERO_REG_EN
    assign w_we = reset & w_supported & (w_rd != 5'd0);
`else
    assign w_we = reset & w_supported;
`endif

    // Observation outputs are forced to 0 while reset is held low.
    assign bus.a_out = reset ? w_a      : '0;
    assign bus.b_out = reset ? w_b      : '0;
    assign bus.w_out = reset ? w_result : '0;

    // Register file: asynchronous clear, otherwise write back rd on the rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_rd] <= w_result;
        end
    end

endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core: directed self-checking bench for proc_core.
// Each step drives an instruction on the falling edge and samples 1 ns later.
// The next step's falling edge comes after a rising edge, so every step's
// write-back is committed before the following instruction is applied.
// Expected values are hand-computed from the RISC-V encodings.
module tb_proc_core;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [31:0] exp_regs [32];

    proc_core_if #(.XLEN(32)) bus ();

    proc_core #(.XLEN(32), .NREGS(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation: 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present an instruction on the falling edge and let the combinational outputs settle
    task automatic apply(input logic [31:0] v);
        @(negedge clk);
        bus.ir = v;
        #1;
    endtask

    // Read every register through a and b using an unsupported opcode.
    // rd is set to the register being read, so a stray write would corrupt
    // the later reads.
    task automatic readback(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 32'h0000007F | (32'(i) << 7) | (32'(i) << 15) | (32'(i) << 20);
            apply(v);
            check($sformatf("%s_a_r%0d", tag, i), bus.a_out, exp_regs[i]);
            check($sformatf("%s_b_r%0d", tag, i), bus.b_out, exp_regs[i]);
            check($sformatf("%s_w_r%0d", tag, i), bus.w_out, 32'h0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;

        // Reset held with ADDI r0,r0,5 presented: outputs must read 0
        reset  = 1'b0;
        bus.ir = 32'h00500013;
        #1;
        check("rst_a", bus.a_out, 32'h0);
        check("rst_b", bus.b_out, 32'h0);
        check("rst_w", bus.w_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // ADDI r0,r0,5 before and after its own commit
        check("addi0_a", bus.a_out, 32'h0);
        check("addi0_b", bus.b_out, 32'h5);
        check("addi0_w", bus.w_out, 32'h5);
        apply(32'h00500013);
`ifdef ZERO_REG_EN
        check("addi0b_a", bus.a_out, 32'h0);
        check("addi0b_w", bus.w_out, 32'h5);
`else
        check("addi0b_a", bus.a_out, 32'h5);
        check("addi0b_w", bus.w_out, 32'hA);
`endif

        // Short reset pulse during the low phase to return r0 to 0
        @(negedge clk);
        bus.ir = 32'h0000007F;
        reset  = 1'b0;
        #1;
        check("pulse_w", bus.w_out, 32'h0);
        reset = 1'b1;

        // ADDI r1,r0,-1
        apply(32'hFFF00093);
        check("addi1_a", bus.a_out, 32'h0);
        check("addi1_b", bus.b_out, 32'hFFFFFFFF);
        check("addi1_w", bus.w_out, 32'hFFFFFFFF);
        exp_regs[1] = 32'hFFFFFFFF;
        // SLTIU r2,r1,1 : unsigned 0xFFFFFFFF < 1 is false
        apply(32'h0010B113);
        check("sltiu_a", bus.a_out, 32'hFFFFFFFF);
        check("sltiu_b", bus.b_out, 32'h1);
        check("sltiu_w", bus.w_out, 32'h0);
        // SLTI r2,r1,1 : signed -1 < 1 is true
        apply(32'h0010A113);
        check("slti_w", bus.w_out, 32'h1);
        exp_regs[2] = 32'h1;
        // ADDI r3,r0,1
        apply(32'h00100193);
        check("addi3_w", bus.w_out, 32'h1);
        exp_regs[3] = 32'h1;
        // SUB r4,r3,r1 : 1 - (-1) = 2
        apply(32'h40118233);
        check("sub_a", bus.a_out, 32'h1);
        check("sub_b", bus.b_out, 32'hFFFFFFFF);
        check("sub_w", bus.w_out, 32'h2);
        exp_regs[4] = 32'h2;
        // SRA r5,r1,r3
        apply(32'h4030D2B3);
        check("sra_w", bus.w_out, 32'hFFFFFFFF);
        // SRL r5,r1,r3
        apply(32'h0030D2B3);
        check("srl_w", bus.w_out, 32'h7FFFFFFF);
        exp_regs[5] = 32'h7FFFFFFF;
        // LUI r6,0x12345 : rs1 field decodes as r8, which is 0
        apply(32'h12345337);
        check("lui_a", bus.a_out, 32'h0);
        check("lui_b", bus.b_out, 32'h12345000);
        check("lui_w", bus.w_out, 32'h12345000);
        // ADDI r6,r6,0x678
        apply(32'h67830313);
        check("addi6_a", bus.a_out, 32'h12345000);
        check("addi6_w", bus.w_out, 32'h12345678);
        exp_regs[6] = 32'h12345678;
        // Unsupported opcode: w_out 0, operands still show the reads (r0)
        apply(32'h0000007F);
        check("unsup_w", bus.w_out, 32'h0);
        check("unsup_a", bus.a_out, 32'h0);
        check("unsup_b", bus.b_out, 32'h0);
        // Unsupported opcode aimed at r6 must not disturb it
        apply(32'h0063037F);
        check("unsup6_a", bus.a_out, 32'h12345678);
        check("unsup6_w", bus.w_out, 32'h0);
        readback("rb1");

        // ADD r7,r1,r6 with live registers, then async reset between edges
        apply(32'h006083B3);
        check("add7_w", bus.w_out, 32'h12345677);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_a", bus.a_out, 32'h0);
        check("midrst_b", bus.b_out, 32'h0);
        check("midrst_w", bus.w_out, 32'h0);
        #1;
        reset = 1'b1;
        #0.5;
        check("post_add7_w", bus.w_out, 32'h0);
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        readback("rb2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
